// File: rtl/evaluate_mob_sum_if.sv
// Bus between the square-evaluator array and the mobility summer: board strobe,
// phase and packed square scores in; tapered score, valid strobe and busy out.
interface evaluate_mob_sum_if #(
  parameter int EVAL_WIDTH   = 16,
  parameter int SQUARE_COUNT = 64,
  parameter int SUM_WIDTH    = EVAL_WIDTH + $clog2(SQUARE_COUNT)
);
  logic                                 board_valid;
  logic [8:0]                           phase;
  logic [SQUARE_COUNT*EVAL_WIDTH-1:0]   eval_mg_in;
  logic [SQUARE_COUNT*EVAL_WIDTH-1:0]   eval_eg_in;
  logic signed [SUM_WIDTH-1:0]          eval;
  logic                                 eval_valid;
  logic                                 busy;

  modport master (
    output board_valid, phase, eval_mg_in, eval_eg_in,
    input  eval, eval_valid, busy
  );

  modport slave (
    input  board_valid, phase, eval_mg_in, eval_eg_in,
    output eval, eval_valid, busy
  );
endinterface

// File: rtl/evaluate_mob_sum.sv
// Sums per-square mg/eg mobility scores LANES at a time and blends them by phase.
// Optional EVAL_MOB_CLAMP_EN saturates the blended score to the EVAL_WIDTH range.
module evaluate_mob_sum #(
  parameter int EVAL_WIDTH    = 16,
  parameter int SQUARE_COUNT  = 64,
  parameter int LANES         = 8,
  parameter int INPUT_LATENCY = 3,
  parameter int SUM_WIDTH     = EVAL_WIDTH + $clog2(SQUARE_COUNT)
) (
  input logic clk,
  input logic reset,
  evaluate_mob_sum_if.slave bus
);

  localparam int SLICES  = SQUARE_COUNT / LANES;
  localparam int SLICE_W = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam int PROD_W  = SUM_WIDTH + 10;
  localparam int BANK_W  = SQUARE_COUNT * EVAL_WIDTH;
  localparam int LANE_W  = LANES * EVAL_WIDTH;

  localparam logic [SLICE_W-1:0]          LAST_SLICE = SLICE_W'(SLICES - 1);
  localparam logic signed [SUM_WIDTH-1:0] CLAMP_MAX  = SUM_WIDTH'(2**(EVAL_WIDTH-1) - 1);
  localparam logic signed [SUM_WIDTH-1:0] CLAMP_MIN  = ~CLAMP_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, BLEND, OUT} state_t;

  state_t                        state;
  logic [INPUT_LATENCY-1:0]      valid_dl;
  logic [INPUT_LATENCY-1:0][8:0] phase_dl;
  logic                          cap_valid;
  logic [8:0]                    phase_in;
  logic [8:0]                    phase_q;
  logic [8:0]                    inv_phase;
  logic [BANK_W-1:0]             mg_bank;
  logic [BANK_W-1:0]             eg_bank;
  logic [SLICE_W-1:0]            slice_idx;
  logic signed [SUM_WIDTH-1:0]   mg_sum, eg_sum;
  logic signed [SUM_WIDTH-1:0]   mg_slice, eg_slice;
  logic signed [PROD_W-1:0]      mg_ext, eg_ext, phase_ext, inv_ext, prod;
  logic signed [SUM_WIDTH-1:0]   blend_res, result;

  assign phase_in  = (bus.phase > 9'd256) ? 9'd256 : bus.phase;
  assign cap_valid = valid_dl[INPUT_LATENCY-1];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_dl <= '0;
      phase_dl <= '0;
    end else begin
      valid_dl[0] <= bus.board_valid;
      phase_dl[0] <= phase_in;
      for (int i = 1; i < INPUT_LATENCY; i++) begin
        valid_dl[i] <= valid_dl[i-1];
        phase_dl[i] <= phase_dl[i-1];
      end
    end
  end

  // NOTE: the score banks are plain storage that is always overwritten on
  // capture before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (cap_valid) begin
      mg_bank <= bus.eval_mg_in;
      eg_bank <= bus.eval_eg_in;
    end else if (state == ACCUM) begin
      mg_bank <= mg_bank >> LANE_W;
      eg_bank <= eg_bank >> LANE_W;
    end
  end

  // NOTE: combinational blocks assign defaults first and use blocking
  // assignments, so no latch is inferred and the running sum reads naturally.
  always_comb begin
    mg_slice = '0;
    eg_slice = '0;
    for (int i = 0; i < LANES; i++) begin
      mg_slice = mg_slice + SUM_WIDTH'($signed(mg_bank[i*EVAL_WIDTH +: EVAL_WIDTH]));
      eg_slice = eg_slice + SUM_WIDTH'($signed(eg_bank[i*EVAL_WIDTH +: EVAL_WIDTH]));
    end
  end

  // Bits above 8 of the product are the floor of prod/256.
  always_comb begin
    inv_phase = 9'd256 - phase_q;
    mg_ext    = PROD_W'(mg_sum);
    eg_ext    = PROD_W'(eg_sum);
    phase_ext = PROD_W'($signed({1'b0, phase_q}));
    inv_ext   = PROD_W'($signed({1'b0, inv_phase}));
    prod      = mg_ext * phase_ext + eg_ext * inv_ext;
    blend_res = prod[SUM_WIDTH+7:8];
`ifdef EVAL_MOB_CLAMP_EN
    if (blend_res > CLAMP_MAX)      result = CLAMP_MAX;
    else if (blend_res < CLAMP_MIN) result = CLAMP_MIN;
    else                            result = blend_res;
`else
    result = blend_res;
`endif
  end

  // A delayed strobe in any state restarts the computation; the newest board wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      mg_sum         <= '0;
      eg_sum         <= '0;
      slice_idx      <= '0;
      phase_q        <= '0;
      bus.eval       <= '0;
      bus.eval_valid <= 1'b0;
      bus.busy       <= 1'b0;
    end else begin
      bus.eval_valid <= 1'b0;
      if (cap_valid) begin
        phase_q   <= phase_dl[INPUT_LATENCY-1];
        mg_sum    <= '0;
        eg_sum    <= '0;
        slice_idx <= '0;
        bus.busy  <= 1'b1;
        state     <= ACCUM;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          ACCUM: begin
            mg_sum    <= mg_sum + mg_slice;
            eg_sum    <= eg_sum + eg_slice;
            slice_idx <= slice_idx + SLICE_W'(1);
            if (slice_idx == LAST_SLICE) state <= BLEND;
          end
          BLEND: begin
            bus.eval       <= result;
            bus.eval_valid <= 1'b1;
            bus.busy       <= 1'b0;
            state          <= OUT;
          end
          OUT:     state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_evaluate_mob_sum.sv
// Randomized self-checking bench for evaluate_mob_sum against a cycle-indexed
// expectation table built from plain integer arithmetic.
module tb_evaluate_mob_sum;

  localparam int EW   = 16;
  localparam int SC   = 64;
  localparam int LN   = 8;
  localparam int LAT  = 3;
  localparam int SW   = EW + $clog2(SC);
  localparam int MAXC = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  evaluate_mob_sum_if #(.EVAL_WIDTH(EW), .SQUARE_COUNT(SC), .SUM_WIDTH(SW)) bus();

  evaluate_mob_sum #(
    .EVAL_WIDTH(EW), .SQUARE_COUNT(SC), .LANES(LN), .INPUT_LATENCY(LAT), .SUM_WIDTH(SW)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .bus(bus)
  );

  int     cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit     exp_valid [MAXC];
  bit     exp_busy  [MAXC];
  longint exp_eval  [MAXC];
  longint hold_eval = 0;
  int     n_checks  = 0;
  int     n_pass    = 0;
  int     mg_v [SC];
  int     eg_v [SC];

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  // Tapered score straight from the definition: weighted sums, floor divide by 256.
  function automatic longint model(input int p);
    longint smg = 0, seg = 0, ps, prod, r;
    for (int i = 0; i < SC; i++) begin
      smg += mg_v[i];
      seg += eg_v[i];
    end
    ps   = (p > 256) ? 256 : p;
    prod = smg * ps + seg * (256 - ps);
    r    = prod / 256;
    if (prod < 0 && (prod % 256) != 0) r = r - 1;
`ifdef EVAL_MOB_CLAMP_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return r;
  endfunction

  always @(negedge clk) begin
    if (cyc < MAXC) begin
      if (!rst_n) begin
        hold_eval = 0;
        check("reset eval", bus.eval, 0);
        check("reset eval_valid", bus.eval_valid, 0);
        check("reset busy", bus.busy, 0);
      end else begin
        if (exp_valid[cyc]) hold_eval = exp_eval[cyc];
        check("eval_valid", bus.eval_valid, exp_valid[cyc]);
        check("busy", bus.busy, exp_busy[cyc]);
        check("eval", bus.eval, hold_eval);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic fill(input int mg, input int eg);
    for (int i = 0; i < SC; i++) begin
      mg_v[i] = mg;
      eg_v[i] = eg;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < SC; i++) begin
      mg_v[i] = int'($urandom_range(0, 65535)) - 32768;
      eg_v[i] = int'($urandom_range(0, 65535)) - 32768;
    end
  endtask

  // Presents one board this cycle; a newer board cancels any result still in flight.
  task automatic board(input int p);
    int c;
    for (int i = 0; i < SC; i++) begin
      bus.eval_mg_in[i*EW +: EW] = EW'(mg_v[i]);
      bus.eval_eg_in[i*EW +: EW] = EW'(eg_v[i]);
    end
    bus.phase       = 9'(p);
    bus.board_valid = 1'b1;
    c = cyc;
    if (c + 13 < MAXC) begin
      for (int k = c + 4; k <= c + 12; k++) begin
        exp_valid[k] = 1'b0;
        exp_busy[k]  = 1'b1;
      end
      exp_valid[c+13] = 1'b1;
      exp_eval[c+13]  = model(p);
    end
    @(posedge clk);
    #1;
    bus.board_valid = 1'b0;
  endtask

  task automatic do_reset(input int len);
    rst_n = 1'b0;
    for (int k = cyc; k < MAXC; k++) begin
      exp_valid[k] = 1'b0;
      exp_busy[k]  = 1'b0;
    end
    idle(len);
    rst_n = 1'b1;
  endtask

  task automatic expect_at(input int c, input string name, input bit want_valid, input longint v);
    do @(negedge clk); while (cyc < c);
    check({name, " valid"}, bus.eval_valid, longint'(want_valid));
    if (want_valid) check(name, bus.eval, v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    bus.board_valid = 1'b0;
    bus.phase       = '0;
    bus.eval_mg_in  = '0;
    bus.eval_eg_in  = '0;
    #2;
    do_reset(3);
    idle(2);

    fill(100, 50);
    check("model mg100 p256", model(256), 6400);
    n = cyc; board(256); expect_at(n + 13, "mg100 p256", 1'b1, 6400);
    n = cyc; board(0);   expect_at(n + 13, "mg100 p0", 1'b1, 3200);
    n = cyc; board(128); expect_at(n + 13, "mg100 p128", 1'b1, 4800);

    fill(-3, 0);
    check("model mg-3 p1", model(1), -1);
    n = cyc; board(1);   expect_at(n + 13, "mg-3 p1 floor", 1'b1, -1);
    n = cyc; board(256); expect_at(n + 13, "mg-3 p256", 1'b1, -192);

    fill(10, 0);
    n = cyc; board(400); expect_at(n + 13, "phase sat 400", 1'b1, 640);

    fill(1000, 0);
`ifdef EVAL_MOB_CLAMP_EN
    n = cyc; board(256); expect_at(n + 13, "clamp mg1000", 1'b1, 32767);
`else
    n = cyc; board(256); expect_at(n + 13, "noclamp mg1000", 1'b1, 64000);
`endif

    // Second board five cycles later supersedes the first.
    fill_random();
    n = cyc; board(int'($urandom_range(0, 256)));
    idle(4);
    fill(1, 0);
    board(256);
    expect_at(n + 13, "restart no early pulse", 1'b0, 0);
    expect_at(n + 18, "restart result", 1'b1, 64);

    // Reset in the middle of accumulation, then a clean board.
    fill_random();
    board(200);
    idle(5);
    do_reset(3);
    idle(2);
    fill(7, 3);
    n = cyc; board(128); expect_at(n + 13, "after reset", 1'b1, 320);

    for (int t = 0; t < 150; t++) begin
      fill_random();
      board(int'($urandom_range(0, 511)));
      if ($urandom_range(0, 40) == 0) do_reset(2);
      idle(int'($urandom_range(3, 13)));
    end

    idle(20);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/evaluate_mob_sum.md
# evaluate_mob_sum

Sums the per-square mobility scores produced by the array of mobility-square evaluators into one tapered mobility term. It captures all square midgame/endgame scores when they become valid and accumulates them LANES at a time. It then blends the midgame and endgame totals by game phase and presents one signed score with a one-cycle valid strobe. It sits directly downstream of the square evaluators and upstream of the board evaluation summer.

## Interface

Parameters:
- EVAL_WIDTH, 16: width of each signed per-square score input.
- SQUARE_COUNT, 64: number of square score pairs; must be a multiple of LANES.
- LANES, 8: scores added per cycle per phase term.
- INPUT_LATENCY, 3: cycles from board_valid to square scores valid at the inputs.
- SUM_WIDTH, EVAL_WIDTH+$clog2(SQUARE_COUNT): accumulator and output width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- board_valid  input  1  single-cycle strobe: new board presented to square evaluators.
- phase  input  9  game phase, 0 = pure endgame, 256 = pure midgame; sampled with board_valid.
- eval_mg_in  input  SQUARE_COUNT*EVAL_WIDTH  packed signed midgame scores, square i at [i*EVAL_WIDTH +: EVAL_WIDTH].
- eval_eg_in  input  SQUARE_COUNT*EVAL_WIDTH  packed signed endgame scores, same packing.
- eval  output  SUM_WIDTH  signed tapered mobility score.
- eval_valid  output  1  high for exactly one cycle when eval is updated.
- busy  output  1  high while states ACCUM or BLEND are active.

## Operation

- Delay line: board_valid and phase are shifted through an INPUT_LATENCY-deep register chain. Phase values above 256 are saturated to 256 on entry.
- FSM states:
  - IDLE: wait for the delayed strobe cap_valid.
  - ACCUM: add one LANES-wide slice of mg and eg per cycle.
  - BLEND: compute the tapered product.
  - OUT: register eval and pulse eval_valid.
- Capture (IDLE or any state, cap_valid high): load the full mg/eg input banks into internal registers. Also load the delayed phase, clear both accumulators, zero the slice index, and go to ACCUM.
- ACCUM: each cycle, mg_sum += sign-extended sum of the LANES mg entries at the current slice; eg_sum likewise. After slice SQUARE_COUNT/LANES-1 go to BLEND.
- BLEND: prod = mg_sum*phase + eg_sum*(256-phase), signed, SUM_WIDTH+10 bits. The result is the arithmetic right shift of prod by 8, floor rounding toward negative infinity. Go to OUT.
- OUT: eval <= result, eval_valid <= 1 for one cycle, then return to IDLE. eval holds its value until the next OUT.
- Restart: cap_valid during ACCUM, BLEND or OUT re-captures and restarts ACCUM on that edge. The aborted board never produces eval_valid (latest board wins). board_valid strobes closer together than one full computation therefore yield one result.
- Arithmetic: all sums are sign-extended to SUM_WIDTH. A convex blend cannot overflow SUM_WIDTH.

## Timing

- Reset values: eval = 0, eval_valid = 0, busy = 0, FSM = IDLE. The delay line, accumulators and slice index are cleared.
- Assertion of reset mid-operation discards the computation immediately, asynchronously; no eval_valid follows.
- Latency: eval_valid is high in cycle N+INPUT_LATENCY+SQUARE_COUNT/LANES+2, where N is the board_valid cycle. With defaults this is N+13.
- busy is high from the cycle after capture through the BLEND cycle.
- Throughput: one result per SQUARE_COUNT/LANES+2 cycles, which is 10 with defaults.

## Configuration

- EVAL_MOB_CLAMP_EN defined: the BLEND result is saturated to the signed EVAL_WIDTH range, [-32768, 32767] with defaults, and then sign-extended onto eval.
- Not defined: eval carries the full SUM_WIDTH result unsaturated. Timing is identical either way.

## Test plan

- All mg = 100, eg = 50, phase = 256 -> eval = 6400 at cycle N+13. Same data with phase = 0 gives 3200; phase = 128 gives 4800.
- All mg = -3, eg = 0, phase = 1 -> eval = -1 (floor of -192/256). With phase = 256, eval = -192.
- Phase input 400 with mg = 10, eg = 0 everywhere -> treated as 256, eval = 640.
- All mg = 1000, phase = 256 -> eval = 32767 with EVAL_MOB_CLAMP_EN; eval = 64000 without it.
- board_valid at N (data A), then again at N+5 (data B: all mg = 1, phase = 256) -> single eval_valid at N+18, eval = 64. No pulse near N+13.
- Reset asserted during ACCUM -> eval = 0, eval_valid stays 0, busy = 0. A subsequent board_valid produces a correct result 13 cycles later.
